cu_seq: RTL and testbench
=========================

# cu_seq

Parametrised instruction-sequencing control unit for the matrix-processing datapath. It fetches an instruction word from instruction memory and decodes the opcode field. It then drives register-decoder enables, ALU control and memory/address-counter strobes as a Moore FSM. Unlike the first-generation unit, it has:
- a memory ready handshake;
- a start/halt/busy lifecycle;
- a real conditional jump;
- illegal-opcode trapping.

## Interface
Parameters:
- BUS_WIDTH, 16, instruction word width
- OPCODE_LEN, 4, opcode field width (≥4); opcode = ir[BUS_WIDTH-1 -: OPCODE_LEN]
- ALU_CTRL_W, 4, alu_ctrl width (≥3)
- TIMEOUT_CYCLES, 255, memory-wait limit (used only with CU_SEQ_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  leave IDLE and begin fetching
- ir  in  BUS_WIDTH  instruction register contents, valid when mem_rdy=1 in a fetch wait
- mem_rdy  in  1  memory access complete (imem or dmem)
- z_flag  in  1  ALU zero flag
- en_decAop, en_decBop, en_decCop  out  1 each  operand-select decoder enables
- en_decAout, en_decBout, en_decCout  out  1 each  output decoder enables
- alu_ctrl  out  ALU_CTRL_W  ALU function (0 pass, 1 add, 2 sub, 3 shl1, 4 shl2, 5 shr4)
- imem_read, dmem_read, dmem_write  out  1 each  memory strobes
- pc_inc, mar_inc, col_inc, row_inc, col_zero, jump  out  1 each  counter strobes
- busy  out  1  state is neither IDLE nor HALT
- halted  out  1  in HALT
- err  out  1  sticky: illegal opcode or memory timeout

## Operation
- Outputs are a pure function of the registered state (Moore). Every output is 0 in IDLE and HALT, except halted (and err once set).
- Reset (async) forces state=IDLE, opcode register=0, all outputs 0, timeout counter 0. This holds even mid-instruction; e.g. dmem_write drops immediately.
- IDLE: start=1 → FETCH_A.
- FETCH_A: en_decAop, en_decAout, en_decCop, en_decCout=1, alu_ctrl=0. Next state is FETCH_M.
- FETCH_M: imem_read=1. Holds until mem_rdy=1; on that edge, latches opcode from ir. Next state is FETCH_I.
- FETCH_I: pc_inc=1. Dispatches on latched opcode:
  - 0x0/0x1 (NOP) → FETCH_A
  - 0x2 → LI_SEL
  - 0x3 → MRD
  - 0x4/5/6/7/8/A → ALU
  - 0x9 → MWR
  - 0xB → JZ_SEL
  - 0xC → MAR
  - 0xD → COL
  - 0xE → ROW
  - 0xF → HALT
  - opcode >0xF (OPCODE_LEN>4) → HALT with err=1
- LI_SEL: en_decAop, en_decCop. Next state LI_MEM: imem_read, wait mem_rdy. Next state LI_WB: en_decAout, en_decCout, alu_ctrl=0, pc_inc. Then FETCH_A.
- MRD: dmem_read until mem_rdy, then FETCH_A.
- MWR: dmem_write until mem_rdy, then FETCH_A.
- ALU: one cycle, then FETCH_A. alu_ctrl by opcode: 4→3, 5→4, 6→5, 7→1, 8→2, A→0.
- JZ_SEL: jump=1 (selects jump address mux), en_decAop, en_decBop.
- JZ_MEM: jump=1, imem_read, wait mem_rdy.
- JZ_CMP: en_decAout, en_decBout, alu_ctrl=2; samples z_flag.
  - z_flag=0 → JZ_TAKE: jump=1, one cycle.
  - z_flag=1 → JZ_SKIP: pc_inc=1, skips the target word.
  - Both → FETCH_A.
- MAR: mar_inc. COL: col_inc. ROW: row_inc and col_zero together. Each lasts one cycle, then FETCH_A.
- HALT: terminal; start ignored; exit only by reset.

## Timing
- Cycle count with mem_rdy tied 1:
  - NOP and ALU/counter ops: 3 and 4 cycles from FETCH_A to the next FETCH_A.
  - LOADIM: 6; LOAD/STORE: 4; JUMPNZ: 7.
- Each wait state adds one cycle per cycle that mem_rdy=0. The strobe stays asserted for the whole wait, including the mem_rdy=1 cycle.
- mem_rdy is ignored outside wait states.
- start is sampled only in IDLE.
- FETCH_A is entered the cycle after start=1.

## Configuration
- CU_SEQ_TIMEOUT_EN defined:
  - A counter runs in every wait state and clears on state exit.
  - When it reaches TIMEOUT_CYCLES with mem_rdy=0, the FSM goes to HALT with err=1.
- Undefined:
  - No counter; waits are unbounded.
  - err is set only by illegal opcodes.

## Test plan
- Reset, start, ir=0x7000, mem_rdy=1:
  - alu_ctrl=1 for exactly one cycle, 4 cycles after start;
  - pc_inc pulses once;
  - then FETCH_A repeats.
- LOADIM (0x2000), with mem_rdy low for 3 cycles in LI_MEM:
  - imem_read held 4 cycles;
  - two pc_inc pulses per instruction;
  - en_decAout/en_decCout high in LI_WB only.
- JUMPNZ (0xB000):
  - z_flag=0 → jump high in JZ_SEL, JZ_MEM and JZ_TAKE, with no pc_inc after JZ_CMP;
  - z_flag=1 → JZ_SKIP pc_inc pulse.
- ROWINC (0xE000) → row_inc and col_zero high in the same single cycle; COLINC (0xD000) → col_inc only.
- END (0xF000) → halted=1, busy=0, start pulses ignored. Reset asserted mid-STORE → dmem_write=0 asynchronously, state IDLE.
- With CU_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, mem_rdy held 0 in FETCH_M → after 8 cycles, halted=1 and err=1. Without the macro, the FSM is still in FETCH_M after 1000 cycles.

Source files
------------

// File: rtl/cu_seq.sv
// cu_seq -- instruction-sequencing control unit (Moore FSM).
//
// Fetches an instruction word, latches its opcode field and steps through
// the micro-sequence for that opcode. Every output depends only on the
// registered state and the latched opcode. The memory waits stretch for as
// long as mem_rdy stays low.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   start             leave IDLE and begin fetching (sampled only in IDLE)
//   ir                instruction word; the opcode field is captured in FETCH_M
//   mem_rdy           memory access complete; only looked at in wait states
//   z_flag            ALU zero flag, sampled in JZ_CMP
//   en_dec*op/*out    operand-select / output decoder enables
//   alu_ctrl          0 pass, 1 add, 2 sub, 3 shl1, 4 shl2, 5 shr4
//   imem_read, dmem_read, dmem_write   memory strobes
//   pc_inc, mar_inc, col_inc, row_inc, col_zero, jump   counter strobes
//   busy, halted, err status (err is sticky until reset)
//
// Optional feature: define CU_SEQ_TIMEOUT_EN to bound every memory wait to
// TIMEOUT_CYCLES cycles; an expired wait halts the unit with err set.

module cu_seq #(
  parameter int BUS_WIDTH      = 16,
  parameter int OPCODE_LEN     = 4,
  parameter int ALU_CTRL_W     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BUS_WIDTH-1:0]  ir,
  input  logic                  mem_rdy,
  input  logic                  z_flag,
  output logic                  en_decAop,
  output logic                  en_decBop,
  output logic                  en_decCop,
  output logic                  en_decAout,
  output logic                  en_decBout,
  output logic                  en_decCout,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  imem_read,
  output logic                  dmem_read,
  output logic                  dmem_write,
  output logic                  pc_inc,
  output logic                  mar_inc,
  output logic                  col_inc,
  output logic                  row_inc,
  output logic                  col_zero,
  output logic                  jump,
  output logic                  busy,
  output logic                  halted,
  output logic                  err
);

  typedef enum logic [4:0] {
    S_IDLE, S_FETCH_A, S_FETCH_M, S_FETCH_I,
    S_LI_SEL, S_LI_MEM, S_LI_WB,
    S_MRD, S_MWR, S_ALU,
    S_JZ_SEL, S_JZ_MEM, S_JZ_CMP, S_JZ_TAKE, S_JZ_SKIP,
    S_MAR, S_COL, S_ROW, S_HALT
  } state_t;

  state_t                state_q, state_d;
  logic [OPCODE_LEN-1:0] opcode_q;
  logic                  err_q;
  logic                  op_illegal;
  logic                  is_wait;
  logic                  tmo_hit;

  // Only the opcode field of the instruction word matters here.
  logic unused_ir;
  assign unused_ir = ^ir[BUS_WIDTH-OPCODE_LEN-1:0];

  // Opcodes beyond 0xF only exist when the field is wider than four bits.
  if (OPCODE_LEN > 4) begin : g_wide_op
    assign op_illegal = |opcode_q[OPCODE_LEN-1:4];
  end else begin : g_narrow_op
    assign op_illegal = 1'b0;
  end

  assign is_wait = (state_q == S_FETCH_M) || (state_q == S_LI_MEM) ||
                   (state_q == S_MRD)     || (state_q == S_MWR)    ||
                   (state_q == S_JZ_MEM);

`ifdef CU_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q;

  // tmo_cnt_q counts wait cycles already spent, so the trip fires on the
  // TIMEOUT_CYCLES-th consecutive cycle without mem_rdy.
  assign tmo_hit = is_wait && !mem_rdy && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tmo_cnt_q <= '0;
    else if (is_wait && (state_d == state_q))
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    else
      tmo_cnt_q <= '0;
  end
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the reset branch clears only control state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_FETCH_M) && mem_rdy)
        opcode_q <= ir[BUS_WIDTH-1 -: OPCODE_LEN];
      if (((state_q == S_FETCH_I) && op_illegal) || tmo_hit)
        err_q <= 1'b1;
    end
  end

  // NOTE: state_d gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_FETCH_A;
      S_FETCH_A: state_d = S_FETCH_M;
      S_FETCH_M: if (mem_rdy) state_d = S_FETCH_I;
      S_FETCH_I: begin
        if (op_illegal) begin
          state_d = S_HALT;
        end else begin
          case (opcode_q[3:0])
            4'h0, 4'h1:                         state_d = S_FETCH_A;
            4'h2:                               state_d = S_LI_SEL;
            4'h3:                               state_d = S_MRD;
            4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA: state_d = S_ALU;
            4'h9:                               state_d = S_MWR;
            4'hB:                               state_d = S_JZ_SEL;
            4'hC:                               state_d = S_MAR;
            4'hD:                               state_d = S_COL;
            4'hE:                               state_d = S_ROW;
            default:                            state_d = S_HALT;
          endcase
        end
      end
      S_LI_SEL:  state_d = S_LI_MEM;
      S_LI_MEM:  if (mem_rdy) state_d = S_LI_WB;
      S_LI_WB:   state_d = S_FETCH_A;
      S_MRD,
      S_MWR:     if (mem_rdy) state_d = S_FETCH_A;
      S_ALU:     state_d = S_FETCH_A;
      S_JZ_SEL:  state_d = S_JZ_MEM;
      S_JZ_MEM:  if (mem_rdy) state_d = S_JZ_CMP;
      S_JZ_CMP:  state_d = z_flag ? S_JZ_SKIP : S_JZ_TAKE;
      S_JZ_TAKE,
      S_JZ_SKIP,
      S_MAR,
      S_COL,
      S_ROW:     state_d = S_FETCH_A;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_IDLE;
    endcase
    if (tmo_hit) state_d = S_HALT;
  end

  always_comb begin
    en_decAop  = 1'b0;
    en_decBop  = 1'b0;
    en_decCop  = 1'b0;
    en_decAout = 1'b0;
    en_decBout = 1'b0;
    en_decCout = 1'b0;
    alu_ctrl   = '0;
    imem_read  = 1'b0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    pc_inc     = 1'b0;
    mar_inc    = 1'b0;
    col_inc    = 1'b0;
    row_inc    = 1'b0;
    col_zero   = 1'b0;
    jump       = 1'b0;
    case (state_q)
      S_FETCH_A: begin
        en_decAop  = 1'b1;
        en_decAout = 1'b1;
        en_decCop  = 1'b1;
        en_decCout = 1'b1;
      end
      S_FETCH_M: imem_read = 1'b1;
      S_FETCH_I: pc_inc    = 1'b1;
      S_LI_SEL: begin
        en_decAop = 1'b1;
        en_decCop = 1'b1;
      end
      S_LI_MEM:  imem_read = 1'b1;
      S_LI_WB: begin
        en_decAout = 1'b1;
        en_decCout = 1'b1;
        pc_inc     = 1'b1;
      end
      S_MRD:     dmem_read  = 1'b1;
      S_MWR:     dmem_write = 1'b1;
      S_ALU: begin
        case (opcode_q[3:0])
          4'h4:    alu_ctrl = ALU_CTRL_W'(3);
          4'h5:    alu_ctrl = ALU_CTRL_W'(4);
          4'h6:    alu_ctrl = ALU_CTRL_W'(5);
          4'h7:    alu_ctrl = ALU_CTRL_W'(1);
          4'h8:    alu_ctrl = ALU_CTRL_W'(2);
          default: alu_ctrl = '0;
        endcase
      end
      S_JZ_SEL: begin
        jump      = 1'b1;
        en_decAop = 1'b1;
        en_decBop = 1'b1;
      end
      S_JZ_MEM: begin
        jump      = 1'b1;
        imem_read = 1'b1;
      end
      S_JZ_CMP: begin
        en_decAout = 1'b1;
        en_decBout = 1'b1;
        alu_ctrl   = ALU_CTRL_W'(2);
      end
      S_JZ_TAKE: jump    = 1'b1;
      S_JZ_SKIP: pc_inc  = 1'b1;
      S_MAR:     mar_inc = 1'b1;
      S_COL:     col_inc = 1'b1;
      S_ROW: begin
        row_inc  = 1'b1;
        col_zero = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy   = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted = (state_q == S_HALT);
  assign err    = err_q;

endmodule

// File: tb/tb_cu_seq.sv
// tb_cu_seq -- directed bench for cu_seq: walks each opcode's micro-sequence
// with hand-computed strobe patterns, stretched memory waits, both jump
// outcomes, halt behaviour, asynchronous reset mid-store and an unanswered
// fetch wait.

module tb_cu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] ir;
  logic        mem_rdy;
  logic        z_flag;
  logic        en_decAop, en_decBop, en_decCop;
  logic        en_decAout, en_decBout, en_decCout;
  logic [3:0]  alu_ctrl;
  logic        imem_read, dmem_read, dmem_write;
  logic        pc_inc, mar_inc, col_inc, row_inc, col_zero, jump;
  logic        busy, halted, err;

  int n_assert = 0;
  int n_fail   = 0;

  // Strobe bit patterns, in the packing order of strb below.
  localparam logic [14:0] AOP  = 15'h4000, BOP  = 15'h2000, COP  = 15'h1000;
  localparam logic [14:0] AOUT = 15'h0800, BOUT = 15'h0400, COUT = 15'h0200;
  localparam logic [14:0] IMEM = 15'h0100, DRD  = 15'h0080, DWR  = 15'h0040;
  localparam logic [14:0] PCI  = 15'h0020, MARI = 15'h0010, COLI = 15'h0008;
  localparam logic [14:0] ROWI = 15'h0004, COLZ = 15'h0002, JMP  = 15'h0001;
  localparam logic [14:0] FETCH_A_PAT = AOP | COP | AOUT | COUT;

  logic [14:0] strb;
  assign strb = {en_decAop, en_decBop, en_decCop, en_decAout, en_decBout,
                 en_decCout, imem_read, dmem_read, dmem_write, pc_inc,
                 mar_inc, col_inc, row_inc, col_zero, jump};

  cu_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ir         (ir),
    .mem_rdy    (mem_rdy),
    .z_flag     (z_flag),
    .en_decAop  (en_decAop),
    .en_decBop  (en_decBop),
    .en_decCop  (en_decCop),
    .en_decAout (en_decAout),
    .en_decBout (en_decBout),
    .en_decCout (en_decCout),
    .alu_ctrl   (alu_ctrl),
    .imem_read  (imem_read),
    .dmem_read  (dmem_read),
    .dmem_write (dmem_write),
    .pc_inc     (pc_inc),
    .mar_inc    (mar_inc),
    .col_inc    (col_inc),
    .row_inc    (row_inc),
    .col_zero   (col_zero),
    .jump       (jump),
    .busy       (busy),
    .halted     (halted),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [15:0] alu_ops [4];
  logic [3:0]  alu_exp [4];

  initial begin
    alu_ops[0] = 16'h4000; alu_exp[0] = 4'd3;
    alu_ops[1] = 16'h5000; alu_exp[1] = 4'd4;
    alu_ops[2] = 16'h6000; alu_exp[2] = 4'd5;
    alu_ops[3] = 16'h8000; alu_exp[3] = 4'd2;

    reset = 1'b1; start = 1'b0; ir = 16'h0000; mem_rdy = 1'b1; z_flag = 1'b0;
    tick(2);
    check("reset_strb",   32'(strb), 32'h0);
    check("reset_alu",    32'(alu_ctrl), 32'h0);
    check("reset_busy",   32'(busy), 32'h0);
    check("reset_halted", 32'(halted), 32'h0);
    check("reset_err",    32'(err), 32'h0);

    reset = 1'b0;
    tick(2);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_strb", 32'(strb), 32'h0);

    // ADD (0x7): FETCH_A, FETCH_M, FETCH_I, ALU, back to FETCH_A.
    ir = 16'h7000; start = 1'b1;
    tick(1);
    start = 1'b0;
    check("add_fetch_a",  32'(strb), 32'(FETCH_A_PAT));
    check("add_fa_alu",   32'(alu_ctrl), 32'h0);
    check("add_fa_busy",  32'(busy), 32'h1);
    tick(1); check("add_fetch_m", 32'(strb), 32'(IMEM));
    tick(1); check("add_fetch_i", 32'(strb), 32'(PCI));
    tick(1); check("add_alu_ctrl", 32'(alu_ctrl), 32'h1);
             check("add_alu_strb", 32'(strb), 32'h0);
    tick(1); check("add_refetch", 32'(strb), 32'(FETCH_A_PAT));
             check("add_alu_done", 32'(alu_ctrl), 32'h0);

    // Remaining ALU opcode encodings.
    for (int i = 0; i < 4; i++) begin
      ir = alu_ops[i];
      tick(3); check("alu_map", 32'(alu_ctrl), 32'(alu_exp[i]));
      tick(1); check("alu_map_refetch", 32'(strb), 32'(FETCH_A_PAT));
    end

    // NOP: three cycles FETCH_A to FETCH_A.
    ir = 16'h0000;
    tick(3); check("nop_3cyc", 32'(strb), 32'(FETCH_A_PAT));

    // LOADIM with three stalled cycles in LI_MEM.
    ir = 16'h2000;
    tick(2); check("li_fetch_i", 32'(strb), 32'(PCI));
    tick(1); check("li_sel", 32'(strb), 32'(AOP | COP));
    mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1); check("li_mem_stall", 32'(strb), 32'(IMEM));
    end
    tick(1); check("li_mem_last", 32'(strb), 32'(IMEM));
    mem_rdy = 1'b1;
    tick(1); check("li_wb", 32'(strb), 32'(AOUT | COUT | PCI));
             check("li_wb_alu", 32'(alu_ctrl), 32'h0);
    tick(1); check("li_refetch", 32'(strb), 32'(FETCH_A_PAT));

    // JUMPNZ taken (z_flag=0).
    ir = 16'hB000; z_flag = 1'b0;
    tick(3); check("jz_sel", 32'(strb), 32'(JMP | AOP | BOP));
    tick(1); check("jz_mem", 32'(strb), 32'(JMP | IMEM));
    tick(1); check("jz_cmp", 32'(strb), 32'(AOUT | BOUT));
             check("jz_cmp_alu", 32'(alu_ctrl), 32'h2);
    tick(1); check("jz_take", 32'(strb), 32'(JMP));
    tick(1); check("jz_take_refetch", 32'(strb), 32'(FETCH_A_PAT));

    // JUMPNZ not taken (z_flag=1) skips the target word.
    z_flag = 1'b1;
    tick(5); check("jz1_cmp", 32'(strb), 32'(AOUT | BOUT));
    tick(1); check("jz_skip", 32'(strb), 32'(PCI));
    tick(1); check("jz_skip_refetch", 32'(strb), 32'(FETCH_A_PAT));
    z_flag = 1'b0;

    // Counter strobes.
    ir = 16'hE000;
    tick(3); check("row_inc", 32'(strb), 32'(ROWI | COLZ));
    tick(1); check("row_refetch", 32'(strb), 32'(FETCH_A_PAT));
    ir = 16'hD000;
    tick(3); check("col_inc", 32'(strb), 32'(COLI));
    tick(1);
    ir = 16'hC000;
    tick(3); check("mar_inc", 32'(strb), 32'(MARI));
    tick(1);

    // LOAD: dmem_read, single cycle with mem_rdy high.
    ir = 16'h3000;
    tick(3); check("mrd", 32'(strb), 32'(DRD));
    tick(1); check("mrd_refetch", 32'(strb), 32'(FETCH_A_PAT));

    // STORE stalled, then reset between clock edges.
    ir = 16'h9000;
    tick(3); check("mwr", 32'(strb), 32'(DWR));
    mem_rdy = 1'b0;
    tick(1); check("mwr_hold", 32'(strb), 32'(DWR));
    #2 reset = 1'b1;
    #1;
    check("rst_async_dwr",  32'(dmem_write), 32'h0);
    check("rst_async_busy", 32'(busy), 32'h0);
    check("rst_async_strb", 32'(strb), 32'h0);
    tick(1);
    reset = 1'b0; mem_rdy = 1'b1;

    // END halts; start is ignored afterwards.
    ir = 16'hF000; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    check("halt_halted", 32'(halted), 32'h1);
    check("halt_busy",   32'(busy), 32'h0);
    check("halt_strb",   32'(strb), 32'h0);
    check("halt_err",    32'(err), 32'h0);
    start = 1'b1;
    tick(2);
    start = 1'b0;
    tick(1);
    check("halt_sticky", 32'(halted), 32'h1);
    check("halt_sticky_busy", 32'(busy), 32'h0);

    // Fetch wait that never completes.
    reset = 1'b1;
    tick(1);
    reset = 1'b0; mem_rdy = 1'b0; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1); check("wait_fetch_m", 32'(strb), 32'(IMEM));
    tick(1000);
`ifdef CU_SEQ_TIMEOUT_EN
    check("tmo_halted", 32'(halted), 32'h1);
    check("tmo_err",    32'(err), 32'h1);
`else
    check("wait_imem",   32'(imem_read), 32'h1);
    check("wait_busy",   32'(busy), 32'h1);
    check("wait_halted", 32'(halted), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
